mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
Pipeline stage between Execute and Writeback in the RV32I core. It registers the Execute result and issues loads and stores to the data cache over a valid/ready request and valid response handshake, stalling upstream while a memory op is outstanding. It aligns store data and byte masks, and extracts and extends load data. It returns the retired value for writeback and a forwarding tap for Execute's `previous` operand.

Parameters:
- XLEN, 32, datapath width; only 32 supported.
- ADDR_W, 32, byte-address width sent to cache.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- ex_valid  in  1  Execute presents an instruction.
- ex_result  in  32  ALU result; effective address for memory ops.
- ex_store_data  in  32  forwarded rs2 value.
- ex_funct3  in  3  access size/sign.
- ex_mem_we  in  1  store.
- ex_mem_re  in  1  load.
- ex_rd  in  5  destination register.
- ex_reg_we  in  1  writes rd.
- stall  out  1  upstream must hold; ex_* not accepted this cycle.
- dc_req_valid  out  1  cache request valid.
- dc_req_ready  in  1  cache accepts request.
- dc_req_addr  out  ADDR_W  word-aligned address, bits[1:0]=0.
- dc_req_we  out  1  1=store.
- dc_req_wdata  out  32  lane-shifted store data.
- dc_req_wmask  out  4  byte enables, 0 for loads.
- dc_resp_valid  in  1  load data valid, one cycle.
- dc_resp_data  in  32  aligned word.
- fwd_valid  out  1  fwd_data usable by Execute.
- fwd_rd  out  5  rd held in M.
- fwd_data  out  32  ALU result held in M.
- wb_valid  out  1  one-cycle retire pulse.
- wb_rd  out  5  retiring rd.
- wb_reg_we  out  1  retiring reg write enable.
- wb_data  out  32  ALU result or extended load data.

Behaviour:
- M register (m_valid, result, store_data, funct3, we, re, rd, reg_we) loads ex_* when !stall; m_valid<=ex_valid.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE with non-memory op in M: retires next cycle.
  - IDLE with memory op in M: next cycle ISSUE.
  - ISSUE: dc_req_valid=1. Hold addr/we/wdata/wmask stable until dc_req_ready.
  - ISSUE, handshake, store: retire; go to IDLE.
  - ISSUE, handshake, load: go to WAIT.
  - WAIT: on dc_resp_valid, retire load; go to IDLE.
- stall = m_valid & (we|re) & !(retiring this cycle). A load or store in M occupies the stage for at least 2 cycles; a non-mem op never stalls.
- Retire: wb_* registered, valid the cycle after completion. wb_valid is high for exactly one cycle. Stores retire with wb_reg_we=0.
- Store lane alignment, off = result[1:0]:
  - SB: wdata = byte replicated x4, wmask = 1<<off.
  - SH: wdata = half replicated x2, wmask = 0011 if off[1]=0, else 1100.
  - SW: wmask = 1111.
- Load extraction selects by off:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: whole word.
  - Undefined funct3 (011, 110, 111): treated as LW/SW.
- dc_resp_valid outside WAIT is ignored.
- fwd_valid = m_valid & ex-type op (not load) & reg_we & rd!=0. Loads never forward from M; the hazard unit handles load-use.
- Simultaneous retire and new accept in the same cycle is allowed (back-to-back ALU ops at 1/cycle).
- Reset (any state, including ISSUE/WAIT):
  - state=IDLE, m_valid=0.
  - All outputs 0: dc_req_valid=0, wb_valid=0, fwd_valid=0, stall=0.
  - An outstanding response arriving after reset is dropped.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Misaligned access (half with off[0]=1, word with off!=0) issues no cache request.
  - Retires next cycle with wb_reg_we=0.
  - Pulses extra output misaligned_o (1 bit, reset 0) for one cycle aligned with wb_valid.
- Undefined:
  - No misaligned_o port.
  - Low offset bits are truncated to natural alignment (off[0] ignored for halves, off ignored for words).

Test Plan:
- ALU op rd=5, result=0x1234 followed by a second ALU op → fwd_valid=1, fwd_data=0x1234 one cycle after accept. wb_valid/wb_data=0x1234 the following cycle. Back-to-back ops never raise stall.
- SB addr=0x1003, data=0x000000AB, dc_req_ready low 3 cycles → req held stable: addr 0x1000, wdata 0xABABABAB, wmask 1000. stall high throughout. wb_valid with wb_reg_we=0 one cycle after the ready handshake.
- LB addr=0x2002, resp word 0x00F00000 after 2 cycles → wb_data 0xFFFFFFF0. LBU on the same word → 0x000000F0.
- LH addr=0x2002, resp 0x8001xxxx → 0xFFFF8001. LHU → 0x00008001. LW → full word.
- rst_n low for one cycle while in WAIT, then dc_resp_valid → no wb_valid; state IDLE; stall=0.
- With MISALIGN_TRAP_EN, LW addr=0x3001 → dc_req_valid never asserted; misaligned_o=1 and wb_valid=1 in the same cycle.

Source files
------------

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   Memory-access pipeline stage of the RV32I core, sitting between Execute
//   and Writeback. Holds the Execute result in the M register, issues loads
//   and stores to the data cache, aligns store data / byte enables, extracts
//   and extends load data, and produces a one-cycle retire pulse for
//   Writeback plus a forwarding tap of the ALU result held in M.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     defined   : misaligned half/word accesses skip the cache, retire the
//                 next cycle with wb_reg_we=0 and pulse misaligned_o.
//     undefined : no misaligned_o port; low offset bits are truncated to
//                 the natural alignment of the access size.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   ex_*                instruction presented by Execute
//   stall               Execute must hold; ex_* not accepted this cycle
//   dc_req_*            cache request channel (valid/ready)
//   dc_resp_*           cache load response (one-cycle valid)
//   fwd_*               ALU result held in M for Execute's forwarding mux
//   wb_*                registered retire pulse towards Writeback
//   misaligned_o        (MISALIGN_TRAP_EN only) misalignment retire flag
// ---------------------------------------------------------------------------
module mem_access_stage #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [XLEN-1:0]   ex_result,
   input  logic [XLEN-1:0]   ex_store_data,
   input  logic [2:0]        ex_funct3,
   input  logic              ex_mem_we,
   input  logic              ex_mem_re,
   input  logic [4:0]        ex_rd,
   input  logic              ex_reg_we,
   output logic              stall,
   output logic              dc_req_valid,
   input  logic              dc_req_ready,
   output logic [ADDR_W-1:0] dc_req_addr,
   output logic              dc_req_we,
   output logic [XLEN-1:0]   dc_req_wdata,
   output logic [3:0]        dc_req_wmask,
   input  logic              dc_resp_valid,
   input  logic [XLEN-1:0]   dc_resp_data,
   output logic              fwd_valid,
   output logic [4:0]        fwd_rd,
   output logic [XLEN-1:0]   fwd_data,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic              wb_reg_we,
   output logic [XLEN-1:0]   wb_data
`ifdef MISALIGN_TRAP_EN
   ,
   output logic              misaligned_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t            state_reg;

   // M register
   logic              m_valid_reg;
   logic [XLEN-1:0]   m_result_reg;
   logic [XLEN-1:0]   m_store_data_reg;
   logic [2:0]        m_funct3_reg;
   logic              m_we_reg;
   logic              m_re_reg;
   logic [4:0]        m_rd_reg;
   logic              m_reg_we_reg;

   // Writeback register
   logic              wb_valid_reg;
   logic [4:0]        wb_rd_reg;
   logic              wb_reg_we_reg;
   logic [XLEN-1:0]   wb_data_reg;
`ifdef MISALIGN_TRAP_EN
   logic              misaligned_reg;
`endif

   logic              m_is_mem;
   logic [1:0]        off;
   logic              is_byte;
   logic              is_half;
   logic              is_word;
   logic              misaligned;
   logic              done_alu;
   logic              done_store;
   logic              done_load;
   logic              retire;

   assign m_is_mem = m_we_reg | m_re_reg;
   assign off      = m_result_reg[1:0];
   // funct3[1:0] gives the size; 11 (undefined) falls into the word case.
   assign is_byte  = (m_funct3_reg[1:0] == 2'b00);
   assign is_half  = (m_funct3_reg[1:0] == 2'b01);
   assign is_word  = !is_byte && !is_half;

`ifdef MISALIGN_TRAP_EN
   assign misaligned = m_is_mem & ((is_half & off[0]) | (is_word & (off != 2'b00)));
`else
   assign misaligned = 1'b0;
`endif

   // Completion events; the retire register captures them at the next edge.
   // Misaligned accesses complete like ALU ops without touching the cache.
   assign done_alu   = m_valid_reg & (state_reg == S_IDLE) & (!m_is_mem | misaligned);
   assign done_store = (state_reg == S_ISSUE) & dc_req_ready & m_we_reg;
   assign done_load  = (state_reg == S_WAIT) & dc_resp_valid;
   assign retire     = done_alu | done_store | done_load;

   // Completion frees the stage in the same cycle so a new op can enter.
   assign stall = m_valid_reg & m_is_mem & !retire;

   // ---------------- store alignment ----------------
   logic [XLEN-1:0] st_wdata;
   logic [3:0]      st_wmask;

   always_comb begin
      st_wdata = m_store_data_reg;
      st_wmask = 4'b1111;
      if (is_byte) begin
         st_wdata = {4{m_store_data_reg[7:0]}};
         st_wmask = 4'b0001 << off;
      end else if (is_half) begin
         st_wdata = {2{m_store_data_reg[15:0]}};
         st_wmask = off[1] ? 4'b1100 : 4'b0011;
      end
      if (!m_we_reg) begin
         st_wmask = 4'b0000;
      end
   end

   assign dc_req_valid = (state_reg == S_ISSUE);
   assign dc_req_addr  = {m_result_reg[ADDR_W-1:2], 2'b00};
   assign dc_req_we    = m_we_reg;
   assign dc_req_wdata = st_wdata;
   assign dc_req_wmask = st_wmask;

   // ---------------- load extraction ----------------
   logic [7:0]  resp_byte [4];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic        sign_ext;
   logic [XLEN-1:0] load_val;

   for (genvar gi = 0; gi < 4; gi++) begin : g_resp_lane
      assign resp_byte[gi] = dc_resp_data[8*gi +: 8];
   end

   assign sel_byte = resp_byte[off];
   assign sel_half = off[1] ? dc_resp_data[31:16] : dc_resp_data[15:0];
   assign sign_ext = ~m_funct3_reg[2];   // LBU/LHU have funct3[2] set

   always_comb begin
      load_val = dc_resp_data;
      if (is_byte) begin
         load_val = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      end else if (is_half) begin
         load_val = {{16{sign_ext & sel_half[15]}}, sel_half};
      end
   end

   // ---------------- M register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_valid_reg      <= 1'b0;
         m_result_reg     <= '0;
         m_store_data_reg <= '0;
         m_funct3_reg     <= 3'b000;
         m_we_reg         <= 1'b0;
         m_re_reg         <= 1'b0;
         m_rd_reg         <= 5'd0;
         m_reg_we_reg     <= 1'b0;
      end else if (!stall) begin
         m_valid_reg      <= ex_valid;
         m_result_reg     <= ex_result;
         m_store_data_reg <= ex_store_data;
         m_funct3_reg     <= ex_funct3;
         m_we_reg         <= ex_mem_we;
         m_re_reg         <= ex_mem_re;
         m_rd_reg         <= ex_rd;
         m_reg_we_reg     <= ex_reg_we;
      end
   end

   // ---------------- access FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         unique case (state_reg)
            S_IDLE: begin
               if (m_valid_reg && m_is_mem && !misaligned) begin
                  state_reg <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (dc_req_ready) begin
                  state_reg <= m_we_reg ? S_IDLE : S_WAIT;
               end
            end
            S_WAIT: begin
               // Responses seen in any other state are simply ignored.
               if (dc_resp_valid) begin
                  state_reg <= S_IDLE;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // ---------------- retire register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_valid_reg  <= 1'b0;
         wb_rd_reg     <= 5'd0;
         wb_reg_we_reg <= 1'b0;
         wb_data_reg   <= '0;
`ifdef MISALIGN_TRAP_EN
         misaligned_reg <= 1'b0;
`endif
      end else begin
         wb_valid_reg <= retire;
`ifdef MISALIGN_TRAP_EN
         misaligned_reg <= done_alu & misaligned;
`endif
         if (retire) begin
            wb_rd_reg     <= m_rd_reg;
            wb_reg_we_reg <= m_reg_we_reg & !m_we_reg & !misaligned;
            wb_data_reg   <= done_load ? load_val : m_result_reg;
         end
      end
   end

   assign wb_valid  = wb_valid_reg;
   assign wb_rd     = wb_rd_reg;
   assign wb_reg_we = wb_reg_we_reg;
   assign wb_data   = wb_data_reg;
`ifdef MISALIGN_TRAP_EN
   assign misaligned_o = misaligned_reg;
`endif

   // Loads never forward from M; load-use is resolved by the hazard unit.
   assign fwd_valid = m_valid_reg & !m_re_reg & !m_we_reg & m_reg_we_reg & (m_rd_reg != 5'd0);
   assign fwd_rd    = m_rd_reg;
   assign fwd_data  = m_result_reg;

endmodule
